// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state codes, S-box tables, RCON and the
// byte/word/key-schedule helper functions used by the iterative inverse cipher.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef logic [1:0] aes_state_t;
    localparam aes_state_t StIdle  = 2'd0;
    localparam aes_state_t StKexp  = 2'd1;
    localparam aes_state_t StRound = 2'd2;
    localparam aes_state_t StDone  = 2'd3;

    // Byte 0 of each table sits in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Indexed 0..15 from the bottom byte; entries 1..10 are the AES-128 constants.
    localparam logic [127:0] RCON = 128'h0000000000361b804020100804020100;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return RCON[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] i);
        return s[{~i, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h000000};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = rk[31:0] ^ rk[63:32];
        p2 = rk[63:32] ^ rk[95:64];
        p1 = rk[95:64] ^ rk[127:96];
        p0 = rk[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] st_next
);

    logic [127:0] ark;
    logic [127:0] mix;
    logic [7:0]   a0, a1, a2, a3;

    always_comb begin
        ark = '0;
        mix = '0;
        a0  = 8'h00;
        a1  = 8'h00;
        a2  = 8'h00;
        a3  = 8'h00;
        // Row r shifts right by r, so output column c draws from input column c-r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[{~4'(4 * c + r), 3'b000} +: 8] =
                    inv_sbox(get_byte(st, 4'(4 * ((c - r) & 3) + r))) ^
                    get_byte(rk, 4'(4 * c + r));
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(ark, 4'(4 * c));
            a1 = get_byte(ark, 4'(4 * c + 1));
            a2 = get_byte(ark, 4'(4 * c + 2));
            a3 = get_byte(ark, 4'(4 * c + 3));
            mix[{~4'(4 * c), 3'b000} +: 8] =
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            mix[{~4'(4 * c + 1), 3'b000} +: 8] =
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            mix[{~4'(4 * c + 2), 3'b000} +: 8] =
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            mix[{~4'(4 * c + 3), 3'b000} +: 8] =
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        st_next = last ? ark : mix;
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: forward key expansion, then one inverse round per cycle.
// Optional round-10 key cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter bit ZERO_OUT_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    aes_state_t   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] rk_fwd, rk_inv, round_out;

`ifdef AES_DEC_KEY_CACHE_EN
    logic         cache_vld_q, cache_vld_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk_q, cache_rk_d;
    logic         cache_hit;
    assign cache_hit = cache_vld_q && (cache_key_q == in_key);
`endif

    assign rk_fwd = key_expand(rk_q, rcon(cnt_q));
    // rk_q holds key cnt+1; undoing its expansion step yields key cnt.
    assign rk_inv = inv_key_expand(rk_q, rcon(cnt_q + 4'd1));

    aes_inv_round u_inv_round (
        .st      (st_q),
        .rk      (rk_inv),
        .last    (cnt_q == 4'd0),
        .st_next (round_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        rk_d    = rk_q;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    st_d    = in_data;
                    rk_d    = in_key;
                    cnt_d   = 4'd1;
                    state_d = StKexp;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_hit) begin
                        st_d    = in_data ^ cache_rk_q;
                        rk_d    = cache_rk_q;
                        cnt_d   = 4'd9;
                        state_d = StRound;
                    end else begin
                        cache_vld_d = 1'b0;
                        cache_key_d = in_key;
                    end
`endif
                end
            end
            StKexp: begin
                rk_d = rk_fwd;
                if (cnt_q == 4'(NR)) begin
                    st_d    = st_q ^ rk_fwd;
                    cnt_d   = 4'd9;
                    state_d = StRound;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_rk_d  = rk_fwd;
                    cache_vld_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRound: begin
                rk_d = rk_inv;
                st_d = round_out;
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            st_q    <= '0;
            rk_q    <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld_q <= 1'b0;
            cache_key_q <= '0;
            cache_rk_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld_q <= cache_vld_d;
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StKexp) || (state_q == StRound);
    assign out_data  = (ZERO_OUT_IDLE && !out_valid) ? '0 : st_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter using FIPS-197 and SP800-38A known-answer vectors.
module tb_aes_decrypt_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           rdy_mode = 0;
    bit           m_vld = 1'b0;
    logic [127:0] m_key = '0;
    logic [127:0] v_key [6];
    logic [127:0] v_ct  [6];
    logic [127:0] v_pt  [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Issue vector v; expected latency counts the acceptance edge as edge 1.
    task automatic issue(input int v, input bit push);
        int   waited;
        bit   hit;
        exp_t e;
        waited = 0;
        hit    = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v_ct[v];
        in_key   = v_key[v];
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready=0, want 1 within 100 cycles");
            in_valid = 1'b0;
            return;
        end
`ifdef AES_DEC_KEY_CACHE_EN
        hit = m_vld && (m_key == v_key[v]);
`endif
        if (!hit) begin
            m_vld = 1'b1;
            m_key = v_key[v];
        end
        e.pt  = v_pt[v];
        e.lat = hit ? 11 : 21;
        e.acc = cyc;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb_q.size());
        end
    endtask

    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        bit           pending;
        logic [127:0] held;
        exp_t         e;
        pending = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
            end else if (out_valid) begin
                if (!pending) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h, want no output", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("plaintext", out_data, e.pt);
                        check("latency", 128'(cyc - e.acc), 128'(e.lat));
                    end
                    held    = out_data;
                    pending = 1'b1;
                end else begin
                    check("out_data_stable", out_data, held);
                end
                if (out_ready) pending = 1'b0;
            end else if (pending) begin
                check("out_valid_held", 128'(out_valid), 128'(1'b1));
                pending = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, want finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        v_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
        v_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        v_pt[0]  = 128'h00112233445566778899aabbccddeeff;
        v_key[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        v_ct[1]  = 128'h3925841d02dc09fbdc118597196a0b32;
        v_pt[1]  = 128'h3243f6a8885a308d313198a2e0370734;
        v_key[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        v_ct[2]  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        v_pt[2]  = 128'h6bc1bee22e409f96e93d7e117393172a;
        v_key[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        v_ct[3]  = 128'hf5d3d58503b9699de785895a96fdbaaf;
        v_pt[3]  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        v_key[4] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        v_ct[4]  = 128'h43b1cd7f598ece23881b00e3ed030688;
        v_pt[4]  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        v_key[5] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        v_ct[5]  = 128'h7b0c785e27e8ad3f8223207104725dd4;
        v_pt[5]  = 128'hf69f2445df4f9b17ad2b417be66c3710;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_key   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_out_data", out_data, '0);
        rst_n = 1'b1;

        // FIPS-197 C.1 and Appendix B vectors.
        issue(0, 1'b1);
        check("busy_in_kexp", 128'(busy), 128'(1'b1));
        check("in_ready_busy", 128'(in_ready), 128'(1'b0));
        drain();
        issue(1, 1'b1);
        drain();

        // Output stall in DONE with in_valid toggling.
        rdy_mode = 2;
        issue(1, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached_done", 128'(out_valid), 128'(1'b1));
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 128'(in_ready), 128'(1'b0));
            in_valid = ~in_valid;
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("stall_release_idle", 128'(in_ready), 128'(1'b1));
        check("stall_release_valid", 128'(out_valid), 128'(1'b0));

        // Same key back-to-back, then a different key.
        issue(0, 1'b1);
        issue(0, 1'b1);
        issue(1, 1'b1);
        drain();

        // Reset in ROUND with cnt=5 aborts the job.
        issue(0, 1'b0);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_vld = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'(1'b0));
        check("abort_in_ready", 128'(in_ready), 128'(1'b1));
        check("abort_busy", 128'(busy), 128'(1'b0));
        check("abort_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 1'b1);
        drain();

        // Back-to-back jobs with random output stalls.
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) begin
            issue(int'($urandom_range(0, 5)), 1'b1);
        end
        drain();
        rdy_mode = 0;
        repeat (5) @(negedge clk);
        check("final_queue_empty", 128'(sb_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
